axil_bk_master: RTL and testbench

- AXI-Lite initiator serving as the master end of the fsic AXI-Lite slave link (no B channel, no RRESP).
- Converts single-cycle backdoor commands (bk_wstart / bk_rstart) into AW+W or AR+R transactions toward an AXI-Lite slave such as the axilite_axis block.
- Returns read data and completion pulses.
- Drives cc_aa_enable for the duration of each transaction.

---
 rtl/axil_bk_pkg.sv | 19 +
 rtl/axil_bk_master_if.sv | 30 +++
 rtl/axil_bk_wdog.sv | 30 +++
 rtl/axil_bk_master.sv | 214 +++++++++++++++++++++
 tb/tb_axil_bk_master.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axil_bk_pkg.sv
// Shared types and defaults for the backdoor AXI-Lite master.
// The optional watchdog is enabled by defining AXIL_M_TIMEOUT_EN.
package axil_bk_pkg;

   localparam int ADDR_W_DEF  = 15;
   localparam int DATA_W_DEF  = 32;
   localparam int TIMEOUT_DEF = 256;

   // Returned as read data when a read is aborted by the watchdog
   localparam logic [31:0] ABORT_DATA = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {
      IDLE,
      WR,
      RD_A,
      RD_D
   } bk_state_e;

endpackage

// File: rtl/axil_bk_master_if.sv
// AXI-Lite write-address, write-data, read-address and read-data channels
// (no B channel, no RRESP) between the backdoor master and its slave.
interface axil_bk_master_if #(
   parameter int ADDR_WIDTH = 15,
   parameter int DATA_WIDTH = 32
);
   logic                    awvalid;
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic                    awready;
   logic                    wvalid;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wready;
   logic                    arvalid;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic                    arready;
   logic                    rvalid;
   logic [DATA_WIDTH-1:0]   rdata;
   logic                    rready;

   modport master (
      output awvalid, awaddr, wvalid, wdata, wstrb, arvalid, araddr, rready,
      input  awready, wready, arready, rvalid, rdata
   );

   modport slave (
      input  awvalid, awaddr, wvalid, wdata, wstrb, arvalid, araddr, rready,
      output awready, wready, arready, rvalid, rdata
   );
endinterface

// File: rtl/axil_bk_wdog.sv
// Transaction watchdog, only built when AXIL_M_TIMEOUT_EN is defined.
// count holds the 1-based index of the cycle currently spent in a busy state.
module axil_bk_wdog
   import axil_bk_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart,
   input  logic active,
   output logic expire
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (restart)
         count <= CW'(1);
      else if (active)
         count <= count + 1'b1;
   end

   // Firing one cycle early lets the registered abort land on cycle TIMEOUT_CYCLES
   assign expire = active && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/axil_bk_master.sv
// Backdoor-command to AXI-Lite initiator; every output is registered.
// Define AXIL_M_TIMEOUT_EN to build the watchdog that aborts stalled transactions.
module axil_bk_master
   import axil_bk_pkg::*;
#(
   parameter int ADDR_WIDTH     = ADDR_W_DEF,
   parameter int DATA_WIDTH     = DATA_W_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
   input  logic                    axi_aclk,
   input  logic                    axi_aresetn,
   input  logic                    bk_wstart,
   input  logic [ADDR_WIDTH-1:0]   bk_waddr,
   input  logic [DATA_WIDTH-1:0]   bk_wdata,
   input  logic [DATA_WIDTH/8-1:0] bk_wstrb,
   input  logic                    bk_rstart,
   input  logic [ADDR_WIDTH-1:0]   bk_raddr,
   output logic [DATA_WIDTH-1:0]   bk_rdata,
   output logic                    bk_rdone,
   output logic                    bk_wdone,
   output logic                    bk_busy,
   output logic                    bk_timeout,
   axil_bk_master_if.master        axi,
   output logic                    cc_aa_enable
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   bk_state_e               state, state_n;
   logic                    pend_rd, pend_rd_n;
   logic [ADDR_WIDTH-1:0]   pend_raddr, pend_raddr_n;
   logic                    awvalid, awvalid_n;
   logic [ADDR_WIDTH-1:0]   awaddr, awaddr_n;
   logic                    wvalid, wvalid_n;
   logic [DATA_WIDTH-1:0]   wdata, wdata_n;
   logic [STRB_WIDTH-1:0]   wstrb, wstrb_n;
   logic                    arvalid, arvalid_n;
   logic [ADDR_WIDTH-1:0]   araddr, araddr_n;
   logic                    rready, rready_n;
   logic [DATA_WIDTH-1:0]   rdata, rdata_n;
   logic                    rdone, rdone_n;
   logic                    wdone, wdone_n;
   logic                    busy, busy_n;
   logic                    tout, tout_n;
   logic                    cc_en, cc_en_n;
   logic                    expire;
   logic                    aw_ok, w_ok;

`ifdef AXIL_M_TIMEOUT_EN
   axil_bk_wdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_wdog (
      .clk     (axi_aclk),
      .rst_n   (axi_aresetn),
      .restart ((state_n != state) && (state_n != IDLE)),
      .active  (state != IDLE),
      .expire  (expire)
   );
`else
   assign expire = 1'b0;
`endif

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         state      <= IDLE;
         pend_rd    <= 1'b0;
         pend_raddr <= '0;
         awvalid    <= 1'b0;
         awaddr     <= '0;
         wvalid     <= 1'b0;
         wdata      <= '0;
         wstrb      <= '0;
         arvalid    <= 1'b0;
         araddr     <= '0;
         rready     <= 1'b0;
         rdata      <= '0;
         rdone      <= 1'b0;
         wdone      <= 1'b0;
         busy       <= 1'b0;
         tout       <= 1'b0;
         cc_en      <= 1'b0;
      end else begin
         state      <= state_n;
         pend_rd    <= pend_rd_n;
         pend_raddr <= pend_raddr_n;
         awvalid    <= awvalid_n;
         awaddr     <= awaddr_n;
         wvalid     <= wvalid_n;
         wdata      <= wdata_n;
         wstrb      <= wstrb_n;
         arvalid    <= arvalid_n;
         araddr     <= araddr_n;
         rready     <= rready_n;
         rdata      <= rdata_n;
         rdone      <= rdone_n;
         wdone      <= wdone_n;
         busy       <= busy_n;
         tout       <= tout_n;
         cc_en      <= cc_en_n;
      end
   end

   // A channel counts as finished once its valid has dropped or is handshaking now
   assign aw_ok = !awvalid || axi.awready;
   assign w_ok  = !wvalid  || axi.wready;

   always_comb begin
      state_n      = state;
      pend_rd_n    = pend_rd;
      pend_raddr_n = pend_raddr;
      awvalid_n    = awvalid;
      awaddr_n     = awaddr;
      wvalid_n     = wvalid;
      wdata_n      = wdata;
      wstrb_n      = wstrb;
      arvalid_n    = arvalid;
      araddr_n     = araddr;
      rready_n     = rready;
      rdata_n      = rdata;
      rdone_n      = 1'b0;
      wdone_n      = 1'b0;
      tout_n       = 1'b0;
      cc_en_n      = cc_en;

      case (state)
         IDLE: begin
            if (pend_rd) begin
               pend_rd_n = 1'b0;
               arvalid_n = 1'b1;
               araddr_n  = pend_raddr;
               cc_en_n   = 1'b1;
               state_n   = RD_A;
            end else if (bk_wstart) begin
               awvalid_n = 1'b1;
               awaddr_n  = bk_waddr;
               wvalid_n  = 1'b1;
               wdata_n   = bk_wdata;
               wstrb_n   = bk_wstrb;
               cc_en_n   = 1'b1;
               state_n   = WR;
               if (bk_rstart) begin
                  pend_rd_n    = 1'b1;
                  pend_raddr_n = bk_raddr;
               end
            end else if (bk_rstart) begin
               arvalid_n = 1'b1;
               araddr_n  = bk_raddr;
               cc_en_n   = 1'b1;
               state_n   = RD_A;
            end else begin
               cc_en_n = 1'b0;
            end
         end
         WR: begin
            if (awvalid && axi.awready) awvalid_n = 1'b0;
            if (wvalid && axi.wready)   wvalid_n  = 1'b0;
            if (aw_ok && w_ok) begin
               wdone_n = 1'b1;
               state_n = IDLE;
            end
         end
         RD_A: begin
            if (arvalid && axi.arready) begin
               arvalid_n = 1'b0;
               rready_n  = 1'b1;
               state_n   = RD_D;
            end
         end
         RD_D: begin
            if (axi.rvalid && rready) begin
               rdata_n  = axi.rdata;
               rready_n = 1'b0;
               rdone_n  = 1'b1;
               state_n  = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase

      // Watchdog abort overrides whatever the channel logic decided this cycle
      if (expire) begin
         awvalid_n = 1'b0;
         wvalid_n  = 1'b0;
         arvalid_n = 1'b0;
         rready_n  = 1'b0;
         cc_en_n   = 1'b0;
         pend_rd_n = 1'b0;
         wdone_n   = 1'b0;
         tout_n    = 1'b1;
         state_n   = IDLE;
         if ((state == RD_A) || (state == RD_D)) begin
            rdata_n = DATA_WIDTH'(ABORT_DATA);
            rdone_n = 1'b1;
         end
      end

      busy_n = (state_n != IDLE) || pend_rd_n;
   end

   assign axi.awvalid  = awvalid;
   assign axi.awaddr   = awaddr;
   assign axi.wvalid   = wvalid;
   assign axi.wdata    = wdata;
   assign axi.wstrb    = wstrb;
   assign axi.arvalid  = arvalid;
   assign axi.araddr   = araddr;
   assign axi.rready   = rready;
   assign bk_rdata     = rdata;
   assign bk_rdone     = rdone;
   assign bk_wdone     = wdone;
   assign bk_busy      = busy;
   assign bk_timeout   = tout;
   assign cc_aa_enable = cc_en;

endmodule

// File: tb/tb_axil_bk_master.sv
// Directed self-checking bench for axil_bk_master; the abort scenario runs
// only when AXIL_M_TIMEOUT_EN is defined (watchdog shortened to 16 cycles).
module tb_axil_bk_master;
   import axil_bk_pkg::*;

`ifdef AXIL_M_TIMEOUT_EN
   localparam int TO_CYCLES = 16;
`else
   localparam int TO_CYCLES = 256;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        bk_wstart = 1'b0;
   logic [14:0] bk_waddr = '0;
   logic [31:0] bk_wdata = '0;
   logic [3:0]  bk_wstrb = '0;
   logic        bk_rstart = 1'b0;
   logic [14:0] bk_raddr = '0;
   logic [31:0] bk_rdata;
   logic        bk_rdone, bk_wdone, bk_busy, bk_timeout, cc_aa_enable;

   int assertCount = 0;
   int failCount   = 0;

   axil_bk_master_if #(.ADDR_WIDTH(15), .DATA_WIDTH(32)) axi ();

   axil_bk_master #(
      .ADDR_WIDTH     (15),
      .DATA_WIDTH     (32),
      .TIMEOUT_CYCLES (TO_CYCLES)
   ) dut (
      .axi_aclk     (clk),
      .axi_aresetn  (rst_n),
      .bk_wstart    (bk_wstart),
      .bk_waddr     (bk_waddr),
      .bk_wdata     (bk_wdata),
      .bk_wstrb     (bk_wstrb),
      .bk_rstart    (bk_rstart),
      .bk_raddr     (bk_raddr),
      .bk_rdata     (bk_rdata),
      .bk_rdone     (bk_rdone),
      .bk_wdone     (bk_wdone),
      .bk_busy      (bk_busy),
      .bk_timeout   (bk_timeout),
      .axi          (axi),
      .cc_aa_enable (cc_aa_enable)
   );

   always #5 clk = ~clk;

   // Advance to just after the next rising edge, where inputs change and outputs are sampled
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assertCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic ws, input logic [14:0] wa, input logic [31:0] wd,
                                input logic [3:0] st, input logic rs, input logic [14:0] ra);
      bk_wstart = ws;
      bk_waddr  = wa;
      bk_wdata  = wd;
      bk_wstrb  = st;
      bk_rstart = rs;
      bk_raddr  = ra;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL global time limit: observed running expected finished");
      $fatal(1, "[TB] simulation time limit exceeded");
   end

   initial begin
      axi.awready = 1'b0;
      axi.wready  = 1'b0;
      axi.arready = 1'b0;
      axi.rvalid  = 1'b0;
      axi.rdata   = '0;

      // Reset values
      #2 rst_n = 1'b0;
      tick();
      tick();
      checkOutput("rst awvalid", 32'(axi.awvalid), 32'd0);
      checkOutput("rst arvalid", 32'(axi.arvalid), 32'd0);
      checkOutput("rst rdata",   bk_rdata, 32'd0);
      checkOutput("rst busy",    32'(bk_busy), 32'd0);
      checkOutput("rst cc",      32'(cc_aa_enable), 32'd0);
      rst_n = 1'b1;
      tick();

      // Write with slave ready tied high
      axi.awready = 1'b1;
      axi.wready  = 1'b1;
      applyStimulus(1'b1, 15'h0100, 32'h1234_5678, 4'hF, 1'b0, 15'h0);
      tick();
      applyStimulus(1'b0, 15'h0, 32'h0, 4'h0, 1'b0, 15'h0);
      checkOutput("w1 c1 awvalid", 32'(axi.awvalid), 32'd1);
      checkOutput("w1 c1 wvalid",  32'(axi.wvalid), 32'd1);
      checkOutput("w1 c1 awaddr",  32'(axi.awaddr), 32'h0100);
      checkOutput("w1 c1 wdata",   axi.wdata, 32'h1234_5678);
      checkOutput("w1 c1 wstrb",   32'(axi.wstrb), 32'hF);
      checkOutput("w1 c1 cc",      32'(cc_aa_enable), 32'd1);
      checkOutput("w1 c1 busy",    32'(bk_busy), 32'd1);
      checkOutput("w1 c1 wdone",   32'(bk_wdone), 32'd0);
      tick();
      checkOutput("w1 c2 wdone",   32'(bk_wdone), 32'd1);
      checkOutput("w1 c2 awvalid", 32'(axi.awvalid), 32'd0);
      checkOutput("w1 c2 wvalid",  32'(axi.wvalid), 32'd0);
      checkOutput("w1 c2 cc",      32'(cc_aa_enable), 32'd1);
      tick();
      checkOutput("w1 c3 wdone",   32'(bk_wdone), 32'd0);
      checkOutput("w1 c3 cc",      32'(cc_aa_enable), 32'd0);
      checkOutput("w1 c3 busy",    32'(bk_busy), 32'd0);

      // Skewed write: awready in cycle 3, wready in cycle 5
      axi.awready = 1'b0;
      axi.wready  = 1'b0;
      applyStimulus(1'b1, 15'h0ABC, 32'hA5A5_0F0F, 4'h3, 1'b0, 15'h0);
      tick();
      applyStimulus(1'b0, 15'h0, 32'h0, 4'h0, 1'b0, 15'h0);
      tick();
      checkOutput("w2 c2 awaddr",  32'(axi.awaddr), 32'h0ABC);
      checkOutput("w2 c2 wdone",   32'(bk_wdone), 32'd0);
      tick();
      axi.awready = 1'b1;
      checkOutput("w2 c3 awvalid", 32'(axi.awvalid), 32'd1);
      checkOutput("w2 c3 awaddr",  32'(axi.awaddr), 32'h0ABC);
      tick();
      axi.awready = 1'b0;
      checkOutput("w2 c4 awvalid", 32'(axi.awvalid), 32'd0);
      checkOutput("w2 c4 wvalid",  32'(axi.wvalid), 32'd1);
      checkOutput("w2 c4 wdone",   32'(bk_wdone), 32'd0);
      tick();
      axi.wready = 1'b1;
      checkOutput("w2 c5 wdata",   axi.wdata, 32'hA5A5_0F0F);
      checkOutput("w2 c5 wstrb",   32'(axi.wstrb), 32'h3);
      checkOutput("w2 c5 wdone",   32'(bk_wdone), 32'd0);
      tick();
      axi.wready = 1'b0;
      checkOutput("w2 c6 wdone",   32'(bk_wdone), 32'd1);
      checkOutput("w2 c6 wvalid",  32'(axi.wvalid), 32'd0);
      tick();
      checkOutput("w2 c7 wdone",   32'(bk_wdone), 32'd0);

      // Read: arready in cycle 2, rvalid in cycle 6
      applyStimulus(1'b0, 15'h0, 32'h0, 4'h0, 1'b1, 15'h0204);
      tick();
      applyStimulus(1'b0, 15'h0, 32'h0, 4'h0, 1'b0, 15'h0);
      checkOutput("r1 c1 arvalid", 32'(axi.arvalid), 32'd1);
      checkOutput("r1 c1 araddr",  32'(axi.araddr), 32'h0204);
      checkOutput("r1 c1 cc",      32'(cc_aa_enable), 32'd1);
      tick();
      axi.arready = 1'b1;
      checkOutput("r1 c2 rready",  32'(axi.rready), 32'd0);
      tick();
      axi.arready = 1'b0;
      checkOutput("r1 c3 arvalid", 32'(axi.arvalid), 32'd0);
      checkOutput("r1 c3 rready",  32'(axi.rready), 32'd1);
      tick();
      tick();
      checkOutput("r1 c5 rready",  32'(axi.rready), 32'd1);
      tick();
      axi.rvalid = 1'b1;
      axi.rdata  = 32'hCAFE_0001;
      checkOutput("r1 c6 rready",  32'(axi.rready), 32'd1);
      checkOutput("r1 c6 rdone",   32'(bk_rdone), 32'd0);
      tick();
      axi.rvalid = 1'b0;
      axi.rdata  = 32'h0;
      checkOutput("r1 c7 rdata",   bk_rdata, 32'hCAFE_0001);
      checkOutput("r1 c7 rdone",   32'(bk_rdone), 32'd1);
      checkOutput("r1 c7 rready",  32'(axi.rready), 32'd0);
      checkOutput("r1 c7 cc",      32'(cc_aa_enable), 32'd1);
      tick();
      checkOutput("r1 c8 rdone",   32'(bk_rdone), 32'd0);
      checkOutput("r1 c8 rdata",   bk_rdata, 32'hCAFE_0001);
      checkOutput("r1 c8 cc",      32'(cc_aa_enable), 32'd0);

      // Simultaneous write and read; extra wstart during the sequence is ignored
      axi.awready = 1'b1;
      axi.wready  = 1'b1;
      axi.arready = 1'b1;
      applyStimulus(1'b1, 15'h0010, 32'h0000_00AA, 4'hF, 1'b1, 15'h0020);
      tick();
      applyStimulus(1'b1, 15'h7777, 32'h9999_9999, 4'h1, 1'b0, 15'h0);
      checkOutput("s c1 awaddr",  32'(axi.awaddr), 32'h0010);
      checkOutput("s c1 arvalid", 32'(axi.arvalid), 32'd0);
      checkOutput("s c1 busy",    32'(bk_busy), 32'd1);
      tick();
      checkOutput("s c2 wdone",   32'(bk_wdone), 32'd1);
      checkOutput("s c2 busy",    32'(bk_busy), 32'd1);
      checkOutput("s c2 arvalid", 32'(axi.arvalid), 32'd0);
      tick();
      applyStimulus(1'b0, 15'h0, 32'h0, 4'h0, 1'b0, 15'h0);
      checkOutput("s c3 arvalid", 32'(axi.arvalid), 32'd1);
      checkOutput("s c3 araddr",  32'(axi.araddr), 32'h0020);
      checkOutput("s c3 awvalid", 32'(axi.awvalid), 32'd0);
      checkOutput("s c3 busy",    32'(bk_busy), 32'd1);
      checkOutput("s c3 cc",      32'(cc_aa_enable), 32'd1);
      tick();
      axi.rvalid = 1'b1;
      axi.rdata  = 32'h5555_AAAA;
      checkOutput("s c4 rready",  32'(axi.rready), 32'd1);
      checkOutput("s c4 busy",    32'(bk_busy), 32'd1);
      tick();
      axi.rvalid = 1'b0;
      checkOutput("s c5 rdone",   32'(bk_rdone), 32'd1);
      checkOutput("s c5 rdata",   bk_rdata, 32'h5555_AAAA);
      checkOutput("s c5 awvalid", 32'(axi.awvalid), 32'd0);
      tick();
      checkOutput("s c6 busy",    32'(bk_busy), 32'd0);
      checkOutput("s c6 wdone",   32'(bk_wdone), 32'd0);

      // Reset in cycle 2 of a stalled write
      axi.awready = 1'b0;
      axi.wready  = 1'b0;
      axi.arready = 1'b0;
      applyStimulus(1'b1, 15'h0300, 32'h0BAD_F00D, 4'hF, 1'b0, 15'h0);
      tick();
      applyStimulus(1'b0, 15'h0, 32'h0, 4'h0, 1'b0, 15'h0);
      tick();
      checkOutput("rs c2 awvalid pre", 32'(axi.awvalid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("rs awvalid", 32'(axi.awvalid), 32'd0);
      checkOutput("rs wvalid",  32'(axi.wvalid), 32'd0);
      checkOutput("rs cc",      32'(cc_aa_enable), 32'd0);
      checkOutput("rs busy",    32'(bk_busy), 32'd0);
      checkOutput("rs rdata",   bk_rdata, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      checkOutput("rs post wdone", 32'(bk_wdone), 32'd0);
      checkOutput("rs post busy",  32'(bk_busy), 32'd0);
      axi.awready = 1'b1;
      axi.wready  = 1'b1;
      applyStimulus(1'b1, 15'h0304, 32'h0000_1111, 4'hC, 1'b0, 15'h0);
      tick();
      applyStimulus(1'b0, 15'h0, 32'h0, 4'h0, 1'b0, 15'h0);
      checkOutput("rs new c1 wdata", axi.wdata, 32'h0000_1111);
      tick();
      checkOutput("rs new c2 wdone", 32'(bk_wdone), 32'd1);
      tick();
      checkOutput("timeout idle", 32'(bk_timeout), 32'd0);

`ifdef AXIL_M_TIMEOUT_EN
      // Read whose address is never accepted is aborted at transaction cycle 16
      axi.arready = 1'b0;
      applyStimulus(1'b0, 15'h0, 32'h0, 4'h0, 1'b1, 15'h0440);
      tick();
      applyStimulus(1'b0, 15'h0, 32'h0, 4'h0, 1'b0, 15'h0);
      for (int i = 2; i <= 15; i++) tick();
      checkOutput("to c15 timeout", 32'(bk_timeout), 32'd0);
      checkOutput("to c15 arvalid", 32'(axi.arvalid), 32'd1);
      tick();
      checkOutput("to c16 timeout", 32'(bk_timeout), 32'd1);
      checkOutput("to c16 rdone",   32'(bk_rdone), 32'd1);
      checkOutput("to c16 rdata",   bk_rdata, 32'hDEAD_BEEF);
      checkOutput("to c16 arvalid", 32'(axi.arvalid), 32'd0);
      checkOutput("to c16 cc",      32'(cc_aa_enable), 32'd0);
      checkOutput("to c16 busy",    32'(bk_busy), 32'd0);
      tick();
      checkOutput("to c17 timeout", 32'(bk_timeout), 32'd0);
`else
      // Without the watchdog a stalled read simply keeps waiting
      axi.arready = 1'b0;
      applyStimulus(1'b0, 15'h0, 32'h0, 4'h0, 1'b1, 15'h0440);
      tick();
      applyStimulus(1'b0, 15'h0, 32'h0, 4'h0, 1'b0, 15'h0);
      for (int i = 2; i <= 20; i++) tick();
      checkOutput("stall timeout", 32'(bk_timeout), 32'd0);
      checkOutput("stall arvalid", 32'(axi.arvalid), 32'd1);
      checkOutput("stall busy",    32'(bk_busy), 32'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
